// File: rtl/decode_stage.sv
// Instruction decode / operand fetch stage of the 16-bit, 8-register MIPS pipeline.
// Decodes IF/ID, resolves operands through the EX/MEM/WB bypass network, detects load-use hazards.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic        flush,
    output logic [2:0]  rf_addr_1,
    output logic [2:0]  rf_addr_2,
    input  logic [15:0] rf_data_1,
    input  logic [15:0] rf_data_2,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_dst,
    input  logic [15:0] ex_result,
    input  logic        mem_reg_write,
    input  logic [2:0]  mem_dst,
    input  logic [15:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [2:0]  wb_dst,
    input  logic [15:0] wb_data,
    output logic        stall,
    output logic        idex_valid,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_branch,
    output logic        idex_jump,
    output logic [2:0]  idex_alu_op,
    output logic [2:0]  idex_dst,
    output logic [15:0] idex_op1,
    output logic [15:0] idex_op2,
    output logic [15:0] idex_imm
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;

    logic [3:0]  op_s;
    logic [2:0]  rs_s, rt_s, rd_s, funct_s;
    logic        use_rs_s, use_rt_s;
    logic [2:0]  dst_s, alu_op_s;
    logic        reg_write_s, mem_read_s, mem_write_s, branch_s, jump_s;
    logic [15:0] imm_s, op1_s, op2_s;
    logic        hazard_s, bubble_s;

    logic        valid_r, reg_write_r, mem_read_r, mem_write_r, branch_r, jump_r;
    logic [2:0]  alu_op_r, dst_r;
    logic [15:0] op1_r, op2_r, imm_r;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    // Youngest in-flight producer wins; r0 and 000 destinations never forward.
    function automatic logic [15:0] select_operand(
        input logic [2:0]  src,
        input logic [15:0] rf,
        input logic        ex_we,  input logic [2:0] ex_d,  input logic [15:0] ex_v,
        input logic        mem_we, input logic [2:0] mem_d, input logic [15:0] mem_v,
        input logic        wb_we,  input logic [2:0] wb_d,  input logic [15:0] wb_v
    );
        logic [15:0] res;
        if (src == 3'b000)                       res = 16'h0000;
        else if (ex_we && (ex_d == src))         res = ex_v;
        else if (mem_we && (mem_d == src))       res = mem_v;
        else if (wb_we && (wb_d == src))         res = wb_v;
        else                                     res = rf;
        return res;
    endfunction

    assign op_s      = if_instr[15:12];
    assign rs_s      = if_instr[11:9];
    assign rt_s      = if_instr[8:6];
    assign rd_s      = if_instr[5:3];
    assign funct_s   = if_instr[2:0];
    assign rf_addr_1 = rs_s;
    assign rf_addr_2 = rt_s;

    // Instruction decode into control fields and immediate.
    always_comb begin
        use_rs_s    = 1'b0;
        use_rt_s    = 1'b0;
        dst_s       = 3'b000;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        jump_s      = 1'b0;
        alu_op_s    = 3'b000;
        imm_s       = 16'h0000;
        case (op_s)
            OP_R: begin
                use_rs_s = 1'b1; use_rt_s = 1'b1; dst_s = rd_s;
                reg_write_s = 1'b1; alu_op_s = funct_s;
            end
            OP_ADDI: begin
                use_rs_s = 1'b1; dst_s = rt_s; reg_write_s = 1'b1;
                imm_s = sext6(if_instr[5:0]);
            end
            OP_LW: begin
                use_rs_s = 1'b1; dst_s = rt_s; reg_write_s = 1'b1; mem_read_s = 1'b1;
                imm_s = sext6(if_instr[5:0]);
            end
            OP_SW: begin
                use_rs_s = 1'b1; use_rt_s = 1'b1; mem_write_s = 1'b1;
                imm_s = sext6(if_instr[5:0]);
            end
            OP_BEQ: begin
                use_rs_s = 1'b1; use_rt_s = 1'b1; branch_s = 1'b1; alu_op_s = 3'b001;
                imm_s = sext6(if_instr[5:0]);
            end
            OP_J: begin
                jump_s = 1'b1;
                imm_s  = {4'h0, if_instr[11:0]};
            end
            default: begin
                imm_s = 16'h0000;
            end
        endcase
        if (dst_s == 3'b000) begin
            reg_write_s = 1'b0;
        end else begin
            reg_write_s = reg_write_s;
        end
    end

    assign op1_s = select_operand(rs_s, rf_data_1, ex_reg_write, ex_dst, ex_result,
                                  mem_reg_write, mem_dst, mem_result, wb_reg_write, wb_dst, wb_data);
    assign op2_s = select_operand(rt_s, rf_data_2, ex_reg_write, ex_dst, ex_result,
                                  mem_reg_write, mem_dst, mem_result, wb_reg_write, wb_dst, wb_data);

    // A load in EX cannot be forwarded yet; only sources the op actually reads matter.
    assign hazard_s = if_valid && ex_mem_read && (ex_dst != 3'b000) &&
                      ((use_rs_s && (ex_dst == rs_s)) || (use_rt_s && (ex_dst == rt_s)));
    assign stall    = hazard_s && !flush;
    assign bubble_s = flush || stall || !if_valid;

    // ID/EX pipeline register; bubbles clear every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble_s) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            branch_r    <= 1'b0;
            jump_r      <= 1'b0;
            alu_op_r    <= 3'b000;
            dst_r       <= 3'b000;
            op1_r       <= 16'h0000;
            op2_r       <= 16'h0000;
            imm_r       <= 16'h0000;
        end else begin
            valid_r     <= 1'b1;
            reg_write_r <= reg_write_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            branch_r    <= branch_s;
            jump_r      <= jump_s;
            alu_op_r    <= alu_op_s;
            dst_r       <= dst_s;
            op1_r       <= op1_s;
            op2_r       <= op2_s;
            imm_r       <= imm_s;
        end
    end

    assign idex_valid     = valid_r;
    assign idex_reg_write = reg_write_r;
    assign idex_mem_read  = mem_read_r;
    assign idex_mem_write = mem_write_r;
    assign idex_branch    = branch_r;
    assign idex_jump      = jump_r;
    assign idex_alu_op    = alu_op_r;
    assign idex_dst       = dst_r;
    assign idex_op1       = op1_r;
    assign idex_op2       = op2_r;
    assign idex_imm       = imm_r;

endmodule
